// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with a valid/ready output holding register.
// Ports:
//   clk, rstn        - system clock, asynchronous active-low reset
//   sig              - serial line, idle high, asynchronous to clk
//   data, valid      - received byte, held until accepted with ready
//   ready            - consumer accept; transfer on valid && ready at posedge
//   frame_err        - one-cycle pulse when a stop bit samples low
//   overrun          - one-cycle pulse when a good byte is dropped (holding register full)
module uart_rx #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned BAUD_RATE  = 9600,
    parameter int unsigned CLK_FREQ   = 12_000_000
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  sig,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  valid,
    input  logic                  ready,
    output logic                  frame_err,
    output logic                  overrun
);

    localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);
    localparam int unsigned IDX_W        = $clog2(DATA_WIDTH + 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_t;

    state_t                  state;
    logic [CNT_W-1:0]        clk_cnt;
    logic [IDX_W-1:0]        bit_idx;
    logic [DATA_WIDTH-1:0]   shift_reg;
    logic                    sync_meta;
    logic                    sync;

    // Two-flop synchroniser; resets to the idle (high) line level.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_meta <= 1'b1;
            sync      <= 1'b1;
        end else begin
            sync_meta <= sig;
            sync      <= sync_meta;
        end
    end

    // Receive FSM, bit timing and output holding register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            clk_cnt   <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            data      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;

            // A load in STOP below overrides this and keeps valid high.
            if (valid && ready) begin
                valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (!sync) begin
                        state   <= START;
                        clk_cnt <= '0;
                    end
                end

                // Re-check the line at mid start bit to reject glitches.
                START: begin
                    if (clk_cnt == CNT_W'(HALF_BIT - 1)) begin
                        clk_cnt <= '0;
                        if (!sync) begin
                            state   <= DATA;
                            bit_idx <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + CNT_W'(1);
                    end
                end

                // LSB arrives first; shifting right leaves it in bit 0.
                DATA: begin
                    if (clk_cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
                        clk_cnt   <= '0;
                        shift_reg <= {sync, shift_reg[DATA_WIDTH-1:1]};
                        bit_idx   <= bit_idx + IDX_W'(1);
                        if (bit_idx == IDX_W'(DATA_WIDTH - 1)) begin
                            state <= STOP;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + CNT_W'(1);
                    end
                end

                // Leave at mid stop bit so a following start edge is not missed.
                STOP: begin
                    if (clk_cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
                        clk_cnt <= '0;
                        if (sync) begin
                            if (!valid || ready) begin
                                data  <= shift_reg;
                                valid <= 1'b1;
                            end else begin
                                overrun <= 1'b1;
                            end
                            state <= IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= WAIT_HIGH;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + CNT_W'(1);
                    end
                end

                // Absorb a held-low (break) line so it reports only one error.
                WAIT_HIGH: begin
                    if (sync) begin
                        state <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps
// tb_uart_rx: directed frames into uart_rx with a byte scoreboard and a
// negedge monitor. The bit period is scaled down to keep the run short.
module tb_uart_rx;

    localparam int unsigned BAUD = 9600;
    localparam int unsigned CPB  = 100;
    localparam int unsigned CLKF = BAUD * CPB;
    localparam int unsigned HALF = CPB / 2;
    localparam int          LAT  = 2 + HALF + 9 * CPB + 1;

    logic       clk   = 1'b0;
    logic       rstn  = 1'b0;
    logic       sig   = 1'b1;
    logic       ready = 1'b0;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       overrun;

    uart_rx #(
        .DATA_WIDTH (8),
        .BAUD_RATE  (BAUD),
        .CLK_FREQ   (CLKF)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .sig       (sig),
        .data      (data),
        .valid     (valid),
        .ready     (ready),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] exp_q[$];
    int tests = 0;
    int fails = 0;
    int fe_cnt = 0, ov_cnt = 0, xfer_cnt = 0, rise_cnt = 0;
    int unexp_cnt = 0, both_cnt = 0;
    int rise_cyc = -1, fall_cyc = -1, ov_cyc = -1;
    logic prev_valid = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_win(input string name, input int act, input int lo, input int hi);
        tests++;
        if (act < lo || act > hi) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Monitor: every negedge with valid && ready is exactly one transfer.
    always @(negedge clk) begin
        if (rstn) begin
            if (frame_err) fe_cnt++;
            if (overrun) begin
                ov_cnt++;
                ov_cyc = cyc;
            end
            if (frame_err && overrun) both_cnt++;
            if (valid && !prev_valid) begin
                rise_cnt++;
                rise_cyc = cyc;
            end
            if (!valid && prev_valid) fall_cyc = cyc;
            if (valid && ready) begin
                xfer_cnt++;
                if (exp_q.size() == 0) begin
                    unexp_cnt++;
                    $display("FAIL unexpected_byte: got 0x%0h with empty scoreboard", data);
                end else begin
                    check("scoreboard_data", int'(data), int'(exp_q.pop_front()));
                end
            end
        end
        prev_valid = valid;
    end

    task automatic hold(input logic v, input int n);
        sig = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input int cpb, input logic stop);
        hold(1'b0, cpb);
        for (int i = 0; i < 8; i++) hold(b[i], cpb);
        hold(stop, cpb);
        sig = 1'b1;
    endtask

    task automatic clear_counts();
        fe_cnt   = 0;
        ov_cnt   = 0;
        xfer_cnt = 0;
        rise_cnt = 0;
        rise_cyc = -1;
        fall_cyc = -1;
        ov_cyc   = -1;
    endtask

    int start1, start2;
    logic [7:0] part;

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_data", int'(data), 0);
        check("rst_valid", int'(valid), 0);
        check("rst_frame_err", int'(frame_err), 0);
        check("rst_overrun", int'(overrun), 0);
        @(posedge clk); #1;
        rstn = 1'b1;
        hold(1'b1, 20);

        // 0xA5 with ready high: latency and single-cycle valid
        ready = 1'b1;
        clear_counts();
        exp_q.push_back(8'hA5);
        start1 = cyc;
        send(8'hA5, CPB, 1'b1);
        hold(1'b1, 20);
        check_win("a5_latency", rise_cyc - start1, LAT - 2, LAT + 2);
        check("a5_valid_one_cycle", fall_cyc - rise_cyc, 1);
        check("a5_xfers", xfer_cnt, 1);
        check("a5_frame_err", fe_cnt, 0);
        check("a5_overrun", ov_cnt, 0);

        // 0x3C then 0x7E back-to-back with ready low: overrun on the second
        ready = 1'b0;
        clear_counts();
        exp_q.push_back(8'h3C);
        send(8'h3C, CPB, 1'b1);
        start2 = cyc;
        send(8'h7E, CPB, 1'b1);
        hold(1'b1, 20);
        @(negedge clk);
        check("ovr_valid_held", int'(valid), 1);
        check("ovr_data_kept", int'(data), 8'h3C);
        check("ovr_pulses", ov_cnt, 1);
        check_win("ovr_timing", ov_cyc - start2, LAT - 2, LAT + 2);
        check("ovr_frame_err", fe_cnt, 0);
        @(posedge clk); #1;
        ready = 1'b1;
        hold(1'b1, 5);
        check("ovr_xfers", xfer_cnt, 1);
        @(negedge clk);
        check("ovr_valid_cleared", int'(valid), 0);

        // 0x55 with a low stop bit, break held, then 0x12
        @(posedge clk); #1;
        clear_counts();
        send(8'h55, CPB, 1'b0);
        hold(1'b0, 240);
        hold(1'b1, 50);
        check("break_frame_err", fe_cnt, 1);
        check("break_no_valid", rise_cnt, 0);
        exp_q.push_back(8'h12);
        send(8'h12, CPB, 1'b1);
        hold(1'b1, 20);
        check("after_break_xfers", xfer_cnt, 1);
        check("after_break_frame_err", fe_cnt, 1);

        // Short low glitch on an idle line, then 0x81
        clear_counts();
        hold(1'b0, 24);
        hold(1'b1, 100);
        check("glitch_no_valid", rise_cnt, 0);
        check("glitch_no_frame_err", fe_cnt, 0);
        exp_q.push_back(8'h81);
        send(8'h81, CPB, 1'b1);
        hold(1'b1, 20);
        check("post_glitch_xfers", xfer_cnt, 1);

        // Hold a byte, then reset during data bit 4 of the next frame
        ready = 1'b0;
        clear_counts();
        send(8'h99, CPB, 1'b1);
        hold(1'b1, 20);
        check("pre_reset_valid", int'(valid), 1);
        part = 8'h6B;
        hold(1'b0, CPB);
        for (int i = 0; i < 4; i++) hold(part[i], CPB);
        hold(part[4], CPB / 2);
        rstn = 1'b0;
        #1;
        check("midreset_data", int'(data), 0);
        check("midreset_valid", int'(valid), 0);
        sig = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        rstn = 1'b1;
        hold(1'b1, 20);
        ready = 1'b1;
        clear_counts();
        exp_q.push_back(8'hF0);
        send(8'hF0, CPB, 1'b1);
        hold(1'b1, 20);
        check("post_reset_xfers", xfer_cnt, 1);
        check("post_reset_flags", fe_cnt + ov_cnt, 0);

        // 0xC3 at +3% and -3% bit period
        clear_counts();
        exp_q.push_back(8'hC3);
        send(8'hC3, CPB + 3, 1'b1);
        hold(1'b1, 30);
        exp_q.push_back(8'hC3);
        send(8'hC3, CPB - 3, 1'b1);
        hold(1'b1, 30);
        check("baud_err_xfers", xfer_cnt, 2);
        check("baud_err_frame_err", fe_cnt, 0);

        // Global end-of-run checks
        check("scoreboard_empty", exp_q.size(), 0);
        check("unexpected_bytes", unexp_cnt, 0);
        check("flags_exclusive", both_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver at the far end of the sequencer's serial link.
- Deserialises 8N1 frames (pitch nibble + step index bytes) on a pin into parallel bytes.
- Presents each byte on a valid/ready handshake.
- Flags framing errors and overruns.
- Sits on a board or test fixture that consumes sequencer edits. Also serves as the loopback checker for the transmit path.

Parameters:
- DATA_WIDTH, 8, payload bits per frame, LSB first.
- BAUD_RATE, 9600, line rate in bits/s.
- CLK_FREQ, 12_000_000, clk frequency in Hz.
- Derived (localparams):
  - CLKS_PER_BIT = CLK_FREQ/BAUD_RATE (integer, 1250 at defaults).
  - HALF_BIT = CLKS_PER_BIT/2 (625).

Ports:
- clk  in  1  system clock.
- rstn  in  1  asynchronous active-low reset.
- sig  in  1  serial line, idle high, asynchronous to clk.
- data  out  DATA_WIDTH  received byte; stable while valid=1.
- valid  out  1  byte available; held until accepted.
- ready  in  1  consumer accepts; transfer when valid&&ready at posedge.
- frame_err  out  1  one-cycle pulse when a stop bit samples 0.
- overrun  out  1  one-cycle pulse when a good byte is dropped because the holding register is full.

Behaviour:
- Reset (rstn=0, asynchronous, takes effect immediately):
  - data=0, valid=0, frame_err=0, overrun=0.
  - State=IDLE, bit counter=0, clock counter=0.
  - Both synchroniser flops=1.
- Reset mid-frame aborts the frame; partial bits are discarded and never presented.
- Input path: 2-flop synchroniser on sig; all decisions use the second flop (sync). Adds 2 cycles of latency.
- States: IDLE, START, DATA, STOP, WAIT_HIGH.
- IDLE: sync==0 -> START, clock counter=0.
- START: count to HALF_BIT-1, then sample sync.
  - sync==0 -> DATA, counter=0, bit index=0.
  - sync==1 -> glitch, return to IDLE with no flags.
- DATA: count to CLKS_PER_BIT-1, sample sync into the shift register.
  - Shift right, new bit enters the MSB, so the first-received bit ends up at data[0].
  - Bit index increments per sample.
  - After DATA_WIDTH samples -> STOP.
- STOP: count to CLKS_PER_BIT-1, sample sync.
  - sync==1 (good frame): deliver, then go directly to IDLE. This is mid-stop-bit, so back-to-back frames with one stop bit are received.
  - sync==0: frame_err=1 for exactly one cycle, byte discarded, valid and data unchanged -> WAIT_HIGH.
- WAIT_HIGH: stay until sync==1, then IDLE. A held-low break line yields exactly one frame_err.
- Deliver rule on a good stop sample:
  - If valid==0, or valid&&ready in the same cycle: data<=shift register, valid<=1 on the next edge.
  - Otherwise: overrun=1 for one cycle, new byte dropped, old data and valid retained.
- Handshake:
  - valid deasserts on the cycle after valid&&ready unless a new byte loads that same edge, in which case valid stays 1 and data updates.
  - ready is ignored while valid=0.
- Latency at defaults: from the falling edge of the start bit on sig to valid rising is 2 + 625 + 9*1250 + 1 = 11878 clocks. The bench tolerance is ±2.
- Widths:
  - Clock counter is $clog2(CLKS_PER_BIT) bits and never exceeds CLKS_PER_BIT-1.
  - Bit index is $clog2(DATA_WIDTH+1) bits.
- Tolerance: correct reception with transmitter bit-period error up to ±4%, by virtue of centre sampling.
- frame_err and overrun are never asserted in the same cycle.

Test Plan:
- ready=1, drive frame 0xA5 at 1250 clocks/bit -> valid high 11878±2 clocks after the start edge with data=0xA5, valid low on the following cycle; frame_err=overrun=0.
- ready=0, drive 0x3C then 0x7E back-to-back -> valid=1 with data=0x3C; one-cycle overrun at the stop sample of the second frame; data stays 0x3C. Raising ready gives one transfer of 0x3C, then valid=0.
- Drive 0x55 with the stop bit at 0, hold the line low 3000 clocks, release high, then drive 0x12 -> exactly one frame_err pulse and no valid for 0x55; then valid with data=0x12.
- 300-clock low glitch on an idle line -> no valid, no frame_err; the next frame 0x81 is received correctly.
- Assert rstn=0 during data bit 4 of a frame -> data=0 and valid=0 immediately. Release with the line high, then drive 0xF0 -> data=0xF0 with no flags.
- Drive 0xC3 at 1288 clocks/bit (+3%) and at 1212 clocks/bit (-3%) -> data=0xC3 both times, no frame_err.
